pipe_hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage MIPS core, sitting beside the ID, EX and MEM stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/fwd_select.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects and the register-match helper used by hazard and forwarding logic.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_STEP   = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // $0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// ALU operand forwarding select for one EX source register; the younger
// EX/MEM result takes precedence over MEM/WB when both match.
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] mem_dest_i,
    input  logic       wb_regwrite_i,
    input  logic [4:0] wb_dest_i,
    output logic [1:0] sel_o
);

    always_comb begin
        if (mem_regwrite_i && reg_hit(mem_dest_i, src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_regwrite_i && reg_hit(wb_dest_i, src_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch flushes,
// operand forwarding, debug halt/single-step drain, and stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_wb_dest,
    input  logic             mem_RegWrite,
    input  logic [4:0]       mem_wb_dest,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_dest,
    output logic             pc_write,
    output logic             pc_src_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;

    logic       take;
    logic       luse;
    logic       flowing;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    assign take    = mem_branch && mem_zero;
    assign luse    = id_valid && ex_MemRead && (reg_hit(ex_wb_dest, id_rs) || reg_hit(ex_wb_dest, id_rt));
    assign flowing = (state_q == ST_RUN) || (state_q == ST_STEP);

    fwd_select u_fwd_a (
        .src_i          (ex_rs),
        .mem_regwrite_i (mem_RegWrite),
        .mem_dest_i     (mem_wb_dest),
        .wb_regwrite_i  (wb_RegWrite),
        .wb_dest_i      (wb_dest),
        .sel_o          (fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .src_i          (ex_rt),
        .mem_regwrite_i (mem_RegWrite),
        .mem_dest_i     (mem_wb_dest),
        .wb_regwrite_i  (wb_RegWrite),
        .wb_dest_i      (wb_dest),
        .sel_o          (fwd_b_raw)
    );

    assign forward_a = rst ? FWD_RF : fwd_a_raw;
    assign forward_b = rst ? FWD_RF : fwd_b_raw;

    always_comb begin
        // NOTE: every output is defaulted before any branch, so no path can infer a latch.
        pc_write      = 1'b0;
        pc_src_branch = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        halt_ack      = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            pc_write    = flowing;
            ifid_write  = flowing;
            idex_bubble = !flowing;
            halt_ack    = (state_q == ST_HALTED);
            // A taken branch redirects even while draining or halted.
            if (take) begin
                pc_write      = 1'b1;
                pc_src_branch = 1'b1;
                ifid_flush    = 1'b1;
                idex_bubble   = 1'b1;
                exmem_flush   = 1'b1;
            end else if (luse) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (drain_cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // The stepped instruction has issued once it is not held by a load-use stall.
                if (!luse || take) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (take) begin
            if (flush_count_q != '1) flush_count_d = flush_count_q + 1'b1;
        end else if (luse) begin
            if (stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
